dpram_port_arbiter: RTL
=======================

# dpram_port_arbiter

Single-clock round-robin arbiter that shares one port of the true dual-port RAM among N_REQ requesters. Each requester presents read/write commands through a valid/ready handshake; the arbiter issues at most one command per cycle onto the RAM port and returns read data tagged with the requester ID. It sits between the client logic and one port (A or B) of the RAM, on that port's clock domain.

## Interface
Parameters:
- WIDTH, 8, RAM data width
- ADDRESS, 6, RAM address width
- N_REQ, 4, number of requesters (2..8)
- MAX_BURST, 4, max consecutive grants to a locked requester (1..15)

Ports:
- clk  in  1  port clock; one clock, reset is synchronous and active-high
- rst  in  1  synchronous active-high reset
- req_valid  in  N_REQ  command valid per requester
- req_we  in  N_REQ  1 = write, 0 = read
- req_lock  in  N_REQ  request to keep grant for a burst
- req_addr  in  N_REQ*ADDRESS  flattened addresses, requester i at [i*ADDRESS +: ADDRESS]
- req_wdata  in  N_REQ*WIDTH  flattened write data
- req_ready  out  N_REQ  one-hot accept, combinational
- ram_addr  out  ADDRESS  to RAM addr port, registered
- ram_data_in  out  WIDTH  to RAM data_in port, registered
- ram_wr_en  out  1  to RAM wr_en port, registered
- ram_data_out  in  WIDTH  from RAM data_out port
- rsp_valid  out  1  read data valid
- rsp_id  out  $clog2(N_REQ)  requester owning rsp_rdata
- rsp_rdata  out  WIDTH  read data

## Operation
- Handshake: command of requester i accepted in cycle N iff req_valid[i] && req_ready[i]. At most one req_ready bit high per cycle; req_ready never high without the matching req_valid.
- FSM states: ARB, LOCKED.
  - ARB: grant first valid requester at or after rr_ptr (wrapping). After a grant to i, rr_ptr <= (i+1) mod N_REQ. If req_lock[i] on the accepted command and MAX_BURST>1: go LOCKED, owner <= i, burst_cnt <= 1.
  - LOCKED: only owner may be granted. On each accepted owner command burst_cnt increments; leave to ARB when burst_cnt reaches MAX_BURST, or owner accepts a command with req_lock=0, or owner drops req_valid (same cycle returns to ARB, no grant that cycle).
- No accepted command: ram_wr_en <= 0, ram_addr/ram_data_in hold.
- RAM reads every cycle; only issued reads produce rsp_valid.
- Simultaneous write and read to same address from different requesters: serialized in grant order; later read sees the earlier write.

## Timing
- Accept in cycle N -> ram_addr/ram_wr_en/ram_data_in driven in N+1 -> RAM samples at end of N+1 -> ram_data_out valid in N+2.
- Read response: rsp_valid=1, rsp_id, rsp_rdata registered from ram_data_out, valid in cycle N+3 (3-cycle latency), one cycle wide. Writes produce no response.
- Throughput: one command per cycle, back-to-back, no bubbles.
- Reset values: ram_wr_en=0, ram_addr=0, ram_data_in=0, rsp_valid=0, rsp_id=0, rsp_rdata=0, rr_ptr=0, state=ARB, burst_cnt=0. req_ready=0 while rst=1.
- Reset mid-operation: in-flight reads discarded (no rsp_valid after reset), locks dropped.

## Structure
- Shared header dpram_arb_defs.vh: FSM state encodings (ARB=1'b0, LOCKED=1'b1), default WIDTH/ADDRESS.
- Sub-module rr_priority_picker: combinational; inputs req vector and rr_ptr, outputs one-hot grant and encoded index.
- 2-stage pipeline of {is_read, id} tracks reads to the response.

## Test plan
- Reset: assert rst 2 cycles with all req_valid=4'hF -> all outputs 0, req_ready=0; first grant after reset goes to requester 0.
- Single write/read: req 1 writes 8'hB5 to 6'h28, later reads 6'h28 -> ram_wr_en=1 one cycle; rsp_valid 3 cycles after read accept, rsp_id=1, rsp_rdata=8'hB5.
- Round-robin: req_valid=4'hF held, no lock -> grants 0,1,2,3,0,... one per cycle, no bubbles.
- Burst lock: req 2 valid with lock, others valid, MAX_BURST=4 -> exactly 4 consecutive grants to 2, then grant 3.
- Read-after-write race: req 0 writes 8'h6F to 6'h3D, req 1 reads 6'h3D same cycle -> write issued first, rsp_rdata=8'h6F to id 1.
- Reset mid-read: accept read, assert rst next cycle -> no rsp_valid ever produced.

Source files
------------

// File: rtl/dpram_port_arbiter_pkg.sv
// Shared types and helpers for the dual-port RAM port arbiter.
// Holds FSM encodings, default widths and a wrap-around index helper.
package dpram_port_arbiter_pkg;

    typedef enum logic {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    localparam int DEF_WIDTH   = 8;
    localparam int DEF_ADDRESS = 6;

    function automatic int wrap_inc(input int i, input int n);
        return (i + 1 >= n) ? 0 : i + 1;
    endfunction

endpackage

// File: rtl/dpram_port_arbiter_rr_priority_picker.sv
// Combinational round-robin picker: first set request at or after ptr.
// Produces both a one-hot grant and its encoded index.
module dpram_port_arbiter_rr_priority_picker #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx
);

    int   j;
    logic found;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        j     = 0;
        for (int k = 0; k < N; k++) begin
            j = int'(ptr) + k;
            if (j >= N) j = j - N;
            if (!found && req[j]) begin
                found    = 1'b1;
                grant[j] = 1'b1;
                idx      = IW'(j);
            end
        end
    end

endmodule

// File: rtl/dpram_port_arbiter.sv
// Round-robin arbiter sharing one RAM port among N_REQ requesters,
// with optional burst locking and ID-tagged read responses.
module dpram_port_arbiter
    import dpram_port_arbiter_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int ADDRESS   = DEF_ADDRESS,
    parameter int N_REQ     = 4,
    parameter int MAX_BURST = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req_valid,
    input  logic [N_REQ-1:0]           req_we,
    input  logic [N_REQ-1:0]           req_lock,
    input  logic [N_REQ*ADDRESS-1:0]   req_addr,
    input  logic [N_REQ*WIDTH-1:0]     req_wdata,
    output logic [N_REQ-1:0]           req_ready,
    output logic [ADDRESS-1:0]         ram_addr,
    output logic [WIDTH-1:0]           ram_data_in,
    output logic                       ram_wr_en,
    input  logic [WIDTH-1:0]           ram_data_out,
    output logic                       rsp_valid,
    output logic [$clog2(N_REQ)-1:0]   rsp_id,
    output logic [WIDTH-1:0]           rsp_rdata
);

    localparam int IW = $clog2(N_REQ);

    arb_state_t       state;
    logic [IW-1:0]    rr_ptr;
    logic [IW-1:0]    owner;
    logic [3:0]       burst_cnt;

    logic [N_REQ-1:0] pick_oh;
    logic [IW-1:0]    pick_idx;
    logic [N_REQ-1:0] grant;
    logic [IW-1:0]    gnt_idx;
    logic             accept;
    logic [ADDRESS-1:0] sel_addr;
    logic [WIDTH-1:0]   sel_wdata;

    // Read tracking: {is_read, id} follows the command to the RAM output
    logic             rd_v1, rd_v2;
    logic [IW-1:0]    rd_id1, rd_id2;

    dpram_port_arbiter_rr_priority_picker #(
        .N  (N_REQ),
        .IW (IW)
    ) u_picker (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (pick_oh),
        .idx   (pick_idx)
    );

    always_comb begin
        grant   = '0;
        gnt_idx = '0;
        if (!rst) begin
            if (state == ARB) begin
                grant   = pick_oh;
                gnt_idx = pick_idx;
            end else begin
                grant   = req_valid & (N_REQ'(1) << owner);
                gnt_idx = owner;
            end
        end
        accept    = |grant;
        sel_addr  = req_addr[gnt_idx*ADDRESS +: ADDRESS];
        sel_wdata = req_wdata[gnt_idx*WIDTH +: WIDTH];
    end

    assign req_ready = grant;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ARB;
            rr_ptr      <= '0;
            owner       <= '0;
            burst_cnt   <= '0;
            ram_addr    <= '0;
            ram_data_in <= '0;
            ram_wr_en   <= 1'b0;
            rd_v1       <= 1'b0;
            rd_v2       <= 1'b0;
            rd_id1      <= '0;
            rd_id2      <= '0;
            rsp_valid   <= 1'b0;
            rsp_id      <= '0;
            rsp_rdata   <= '0;
        end else begin
            ram_wr_en <= 1'b0;
            rd_v1     <= accept && !req_we[gnt_idx];
            rd_id1    <= gnt_idx;
            rd_v2     <= rd_v1;
            rd_id2    <= rd_id1;
            rsp_valid <= rd_v2;
            if (rd_v2) begin
                rsp_id    <= rd_id2;
                rsp_rdata <= ram_data_out;
            end
            if (accept) begin
                ram_addr    <= sel_addr;
                ram_data_in <= sel_wdata;
                ram_wr_en   <= req_we[gnt_idx];
                rr_ptr      <= IW'(wrap_inc(int'(gnt_idx), N_REQ));
            end
            unique case (state)
                ARB: begin
                    if (accept && req_lock[gnt_idx] && MAX_BURST > 1) begin
                        state     <= LOCKED;
                        owner     <= gnt_idx;
                        burst_cnt <= 4'd1;
                    end
                end
                LOCKED: begin
                    if (!req_valid[owner]) begin
                        state     <= ARB;
                        burst_cnt <= '0;
                    end else if (burst_cnt + 4'd1 == 4'(MAX_BURST) ||
                                 !req_lock[owner]) begin
                        state     <= ARB;
                        burst_cnt <= '0;
                    end else begin
                        burst_cnt <= burst_cnt + 4'd1;
                    end
                end
                default: state <= ARB;
            endcase
        end
    end

endmodule
